// File: rtl/uart_rx_device.sv
// UART receiver with a 4-entry receive FIFO and a small CPU register interface.
//   0x01 read : FIFO head (read strobe pops one entry)
//   0x02 read : status {5'b0, overrun, frame_err, data_avail}
//   0x02 write: clears overrun and frame_err
module uart_rx_device #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    input  logic [7:0] address,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    FIFO_FULL = 3'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          push, ferr_set;

    logic          rx_meta, rx_s;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          overrun, frame_err;
    logic          pop, full, do_push, ovr_set, flag_clr;

    // Write data carries no information: any write to 0x02 clears flags.
    logic          unused_dbus_in;
    assign unused_dbus_in = ^dbus_in;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM state, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Frame FSM next state: start at half-bit, data/stop at full-bit intervals.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push        = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = RECOVER;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RECOVER: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop      = enable && read && (address == 8'h01) && (count != 3'd0);
    assign full     = (count == FIFO_FULL);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push  = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign flag_clr = enable && write && (address == 8'h02);

    // FIFO storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, occupancy and sticky error flags (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (ovr_set)       overrun <= 1'b1;
            else if (flag_clr) overrun <= 1'b0;
            if (ferr_set)      frame_err <= 1'b1;
            else if (flag_clr) frame_err <= 1'b0;
        end
    end

    // Combinational register read decode.
    always_comb begin
        dbus_out = '0;
        if (enable) begin
            case (address)
                8'h01:   dbus_out = (count != 3'd0) ? mem[rd_ptr] : 8'h00;
                8'h02:   dbus_out = {5'b0, overrun, frame_err, (count != 3'd0)};
                default: dbus_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_device.sv
// Testbench for uart_rx_device: directed frame sequences, a table of bus
// vectors, and randomized traffic checked against a queue-based model.
module tb_uart_rx_device;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset, rx, enable, write, read;
    logic [7:0] address, dbus_in, dbus_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [7:0] addr;
        logic       rd;
        logic       wr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [15];

    // Reference model state for randomized traffic.
    logic [7:0] q [$];
    logic       m_ovr, m_ferr;

    always #5 clk = ~clk;

    uart_rx_device #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .enable  (enable),
        .address (address),
        .write   (write),
        .read    (read),
        .dbus_in (dbus_in),
        .dbus_out(dbus_out)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Called just after a negedge; samples dbus_out before the next posedge.
    task automatic bus(input logic en, input logic [7:0] a, input logic rd, input logic wr,
                       input logic [7:0] d, output logic [7:0] got);
        enable  = en;
        address = a;
        read    = rd;
        write   = wr;
        dbus_in = d;
        #1 got = dbus_out;
        @(negedge clk);
        enable  = 1'b0;
        address = 8'h00;
        read    = 1'b0;
        write   = 1'b0;
        dbus_in = 8'h00;
    endtask

    task automatic rd_data(input string name, input logic [7:0] exp);
        logic [7:0] g;
        bus(1'b1, 8'h01, 1'b1, 1'b0, 8'h00, g);
        check(name, g, exp);
    endtask

    task automatic rd_status(input string name, input logic [7:0] exp);
        logic [7:0] g;
        bus(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, g);
        check(name, g, exp);
    endtask

    task automatic clear_flags();
        logic [7:0] g;
        bus(1'b1, 8'h02, 1'b0, 1'b1, 8'hA7, g);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] b, a;
        logic       stop;
        int unsigned op;

        reset = 1'b1; rx = 1'b1; enable = 1'b0; write = 1'b0; read = 1'b0;
        address = 8'h00; dbus_in = 8'h00;
        idle(3);
        rd_status("reset_status", 8'h00);
        rd_data("reset_data", 8'h00);
        reset = 1'b0;
        idle(4);

        // Frame 0xBB; status must flip exactly one cycle after the stop sample edge.
        fork
            send_frame(8'hBB, 1'b1);
            begin
                idle(78);
                rd_status("bb_before_push", 8'h00);
                rd_status("bb_after_push", 8'h01);
            end
        join
        rd_status("bb_status", 8'h01);
        rd_data("bb_data", 8'hBB);
        rd_status("bb_status_after", 8'h00);

        // Start glitch: two low cycles only.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2 * CPB);
        rd_status("glitch_status", 8'h00);
        send_frame(8'hC3, 1'b1);
        rd_data("after_glitch_data", 8'hC3);

        // Frame error.
        send_frame(8'h55, 1'b0);
        idle(CPB);
        rd_status("ferr_status", 8'h02);
        rd_data("ferr_no_byte", 8'h00);
        clear_flags();
        rd_status("ferr_cleared", 8'h00);

        // Overrun: five frames with no reads.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd_status("ovr_status", 8'h05);
        for (int i = 1; i <= 4; i++) rd_data("ovr_data", 8'(i));
        rd_status("ovr_status_after", 8'h04);
        rd_data("ovr_empty_pop", 8'h00);
        clear_flags();
        rd_status("ovr_cleared", 8'h00);

        // Push and pop on the same edge with the FIFO full.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        fork
            send_frame(8'h15, 1'b1);
            begin
                idle(78);
                rd_data("full_pushpop_data", 8'h11);
            end
        join
        rd_status("full_pushpop_status", 8'h01);
        for (int i = 0; i < 4; i++) rd_data("full_pushpop_drain", 8'h12 + 8'(i));
        rd_status("full_pushpop_end", 8'h00);

        // Push and pop on the same edge with the FIFO empty.
        fork
            send_frame(8'h66, 1'b1);
            begin
                idle(78);
                rd_data("empty_pushpop_data", 8'h00);
            end
        join
        rd_status("empty_pushpop_status", 8'h01);
        rd_data("empty_pushpop_byte", 8'h66);

        // Reset in the middle of data bit 4, then a full frame.
        send_frame(8'h77, 1'b1);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            b = 8'hA5;
            rx = b[i];
            idle(CPB);
        end
        b = 8'hA5;
        rx = b[4];
        idle(CPB / 2);
        reset = 1'b1;
        idle(2);
        rd_status("in_reset_status", 8'h00);
        reset = 1'b0;
        rx = 1'b1;
        idle(3 * CPB);
        send_frame(8'hA5, 1'b1);
        rd_status("post_reset_status", 8'h01);
        rd_data("post_reset_data", 8'hA5);
        rd_status("post_reset_empty", 8'h00);

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        rd_status("b2b_status", 8'h01);
        rd_data("b2b_first", 8'h12);
        rd_data("b2b_second", 8'h34);
        rd_status("b2b_end", 8'h00);

        // Bus decode table: FIFO holds 0x3C, frame_err set.
        vecs[0]  = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h3C};
        vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h03};
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00};
        vecs[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h03};
        vecs[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 8'h3C};
        vecs[10] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h02};
        vecs[12] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 8'h02};
        vecs[14] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00};
        send_frame(8'h81, 1'b0);
        idle(CPB);
        send_frame(8'h3C, 1'b1);
        for (int i = 0; i < 15; i++) begin
            bus(vecs[i].en, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].din, g);
            check($sformatf("vec%0d", i), g, vecs[i].exp);
        end

        // Randomized traffic against the queue model.
        q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1, 2: begin
                    b    = 8'($urandom);
                    stop = ($urandom_range(0, 4) != 0);
                    idle($urandom_range(0, 12));
                    send_frame(b, stop);
                    if (!stop) begin
                        idle(CPB);
                        m_ferr = 1'b1;
                    end else if (q.size() < 4) begin
                        q.push_back(b);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                3: begin
                    rd_data("rand_data", (q.size() != 0) ? q[0] : 8'h00);
                    if (q.size() != 0) void'(q.pop_front());
                end
                4: rd_status("rand_status", {5'b0, m_ovr, m_ferr, q.size() != 0});
                5: begin
                    bus(1'b1, 8'h02, 1'b0, 1'b1, 8'($urandom), g);
                    check("rand_clear", g, {5'b0, m_ovr, m_ferr, q.size() != 0});
                    m_ovr  = 1'b0;
                    m_ferr = 1'b0;
                end
                default: begin
                    a = 8'($urandom);
                    if (a == 8'h01 || a == 8'h02) a = 8'h80;
                    bus(1'b1, a, 1'($urandom), 1'($urandom), 8'($urandom), g);
                    check("rand_other", g, 8'h00);
                end
            endcase
        end
        rd_status("rand_final_status", {5'b0, m_ovr, m_ferr, q.size() != 0});
        while (q.size() != 0) rd_data("rand_drain", q.pop_front());
        rd_data("rand_drain_empty", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_device.md
UART_RX_DEVICE -- requirements
Module: uart_rx_device

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per serial bit; legal range even values 4..65534.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; fixed at 4 for this revision.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port enable  input  1  CPU bus select for this device.
REQ-007 SHALL have port address  input  8  register address.
REQ-008 SHALL have port write  input  1  single-cycle write strobe, qualified by enable.
REQ-009 SHALL have port read  input  1  single-cycle read strobe, qualified by enable.
REQ-010 SHALL have port dbus_in  input  8  CPU write data.
REQ-011 SHALL have port dbus_out  output  8  CPU read data.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all frame logic uses the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, RECOVER with a bit counter of width ceil(log2(CLKS_PER_BIT)) and a 3-bit bit index.
REQ-014 IDLE: rx_s==0 -> START, counter cleared.
REQ-015 START: at counter == CLKS_PER_BIT/2-1 sample rx_s; 0 -> DATA, counter cleared; 1 -> IDLE as a glitch, with no flags set.
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles, LSB first into shift register; after bit 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> push byte, then IDLE; 0 -> set frame_err, discard byte, then RECOVER.
REQ-018 RECOVER: remain until rx_s==1, then IDLE; no start detection while in RECOVER.
REQ-019 Push into full FIFO SHALL drop the new byte and set overrun; FIFO contents unchanged.
REQ-020 Push and pop in the same cycle with FIFO full SHALL perform both, with no overrun; with FIFO empty, the pop SHALL be ignored and the push SHALL take effect.
REQ-021 Pushed byte SHALL be visible in status and data on the cycle after the STOP sample edge.
REQ-022 Read of address 0x01 (enable && read) SHALL pop one entry; pop on empty FIFO is a no-op.
REQ-023 dbus_out SHALL be combinational: enable && address==0x01 -> FIFO head (0x00 if empty); enable && address==0x02 -> status {5'b0, overrun, frame_err, data_avail}; otherwise 0x00.
REQ-024 data_avail SHALL be 1 iff FIFO count != 0; FIFO read/write pointers wrap modulo 4; count range 0..4.
REQ-025 Write (enable && write) to address 0x02 with any data SHALL clear overrun and frame_err; a set event in the same cycle wins.
REQ-026 Writes to other addresses, and reads of address 0x02, SHALL have no side effects.

Reset
REQ-027 reset SHALL force IDLE, clear counters, shift register, FIFO pointers/count, overrun and frame_err; synchronizer flops are set to 1.
REQ-028 reset mid-frame SHALL abandon the frame; a partial byte is never pushed.
REQ-029 While reset is high, dbus_out SHALL still decode combinationally from the cleared state (status reads 0x00).

Verification (CLKS_PER_BIT=8)
REQ-030 Frame 0xBB (start, 8 bits LSB first, stop), 8 clk/bit -> status 0x01; read 0x01 returns 0xBB; status then 0x00.
REQ-031 rx low for 2 cycles, then high -> no push, status 0x00, FSM back in IDLE.
REQ-032 Frame 0x55 with stop bit 0, then line high -> status 0x02, FIFO empty; write 0x02 -> status 0x00.
REQ-033 Five frames 0x01..0x05 with no reads -> status 0x05; four reads return 0x01, 0x02, 0x03, 0x04; status then 0x04.
REQ-034 reset pulsed during bit 4 of a frame, then full frame 0xA5 -> exactly one byte 0xA5 received, status 0x01.
REQ-035 Back-to-back frames 0x12, 0x34 with zero idle gap -> both received in order, no flags set.
